mem_access_unit: RTL and testbench

- Parametrised memory access controller between the CPU datapath (MAR/MRDR/MWDR) and external RAM.
- Replaces the hard-tied cs/we/oe and size-only steering with a real request/ready handshake.
- Adds byte-lane write enables, sign/zero-extended sub-word reads, alignment checking and a bus timeout.
- Issues one transaction at a time; the state machine raises `done` when the result is ready.

---
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Signal bundle between the CPU datapath, the memory access unit and external RAM.
// The slave modport is the access unit; the master modport drives the CPU and RAM sides.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic              sign;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              cs;
  logic              we;
  logic              oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output req, wr, size, sign, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, err, rdata, cs, we, oe, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req, wr, size, sign, addr, wdata, mem_rdata, mem_ready,
    output busy, done, err, rdata, cs, we, oe, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding memory access controller: byte-lane steering, sub-word extension,
// alignment check and bus timeout. Optional macro MEM_ACCESS_ARM_ROTATE_EN allows rotated misaligned word reads.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LSB_W = $clog2(LANES);
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic              r_wr, r_sign, r_rot;
  logic [1:0]        r_size;
  logic [LSB_W-1:0]  r_off;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy, r_done, r_err, r_cs, r_we, r_oe;
  logic [DATA_W-1:0] r_rdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LANES-1:0]  r_mem_be;

  logic              w_rot, w_misal, w_illegal;
  logic [LSB_W-1:0]  w_off, w_be_off;
  logic [DATA_W-1:0] w_lane, w_wsh, w_rd;

  function automatic logic [LANES-1:0] be_mask(input logic [1:0] sz, input logic [LSB_W-1:0] off);
    logic [LANES-1:0] m;
    case (sz)
      2'b00:   m = LANES'(1);
      2'b01:   m = LANES'(3);
      2'b10:   m = LANES'(4'hF);
      default: m = '1;
    endcase
    return m << off;
  endfunction

  function automatic logic [DATA_W-1:0] lane_rep(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++) begin
      case (sz)
        2'b00:   r[8*i +: 8] = d[7:0];
        2'b01:   r[8*i +: 8] = d[8*(i%2) +: 8];
        2'b10:   r[8*i +: 8] = d[8*(i%4) +: 8];
        default: r[8*i +: 8] = d[8*i +: 8];
      endcase
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extend_rd(input logic [1:0] sz, input logic sgn,
                                                  input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] keep;
    logic              msb;
    case (sz)
      2'b00:   begin keep = DATA_W'(8'hFF);         msb = v[7];        end
      2'b01:   begin keep = DATA_W'(16'hFFFF);      msb = v[15];       end
      2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); msb = v[31];       end
      default: begin keep = '1;                     msb = v[DATA_W-1]; end
    endcase
    return (v & keep) | ((sgn && msb) ? ~keep : '0);
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [1:0] n);
    case (n)
      2'd1:    return {v[7:0],  v[31:8]};
      2'd2:    return {v[15:0], v[31:16]};
      2'd3:    return {v[23:0], v[31:24]};
      default: return v;
    endcase
  endfunction

`ifdef MEM_ACCESS_ARM_ROTATE_EN
  assign w_rot = (bus.size == 2'b10) && !bus.wr && (bus.addr[1:0] != 2'b00);
`else
  assign w_rot = 1'b0;
`endif

  always_comb begin
    w_misal = 1'b0;
    case (bus.size)
      2'b01:   w_misal = bus.addr[0];
      2'b10:   w_misal = (bus.addr[1:0] != 2'b00) && !w_rot;
      2'b11:   w_misal = bus.addr[2:0] != 3'b000;
      default: w_misal = 1'b0;
    endcase
  end

  assign w_illegal = (bus.size == 2'b11) && (DATA_W != 64);
  assign w_off     = bus.addr[LSB_W-1:0];
  // A rotated read fetches the whole aligned word containing the address.
  assign w_be_off  = w_rot ? (w_off & ~LSB_W'(3)) : w_off;

  assign w_lane = bus.mem_rdata >> {r_off, 3'b000};
  assign w_wsh  = bus.mem_rdata >> {(r_off & ~LSB_W'(3)), 3'b000};
  assign w_rd   = r_rot ? extend_rd(2'b10, r_sign, DATA_W'(rotr32(w_wsh[31:0], r_off[1:0])))
                        : extend_rd(r_size, r_sign, w_lane);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_sign      <= 1'b0;
      r_rot       <= 1'b0;
      r_size      <= 2'b00;
      r_off       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_rdata     <= '0;
      r_mem_wdata <= '0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req) begin
          r_wr   <= bus.wr;
          r_size <= bus.size;
          r_sign <= bus.sign;
          r_off  <= w_off;
          r_rot  <= w_rot;
          r_busy <= 1'b1;
          if (w_illegal || w_misal) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // Bus outputs are registered here so they are already valid during SETUP.
            r_cs        <= 1'b1;
            r_we        <= bus.wr;
            r_oe        <= ~bus.wr;
            r_mem_addr  <= {bus.addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
            r_mem_be    <= be_mask(bus.size, w_be_off);
            r_mem_wdata <= lane_rep(bus.size, bus.wdata);
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_ready || r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_cs     <= 1'b0;
            r_we     <= 1'b0;
            r_oe     <= 1'b0;
            r_mem_be <= '0;
            r_done   <= 1'b1;
            r_err    <= ~bus.mem_ready;
            r_state  <= S_DONE;
            if (bus.mem_ready && !r_wr) r_rdata <= w_rd;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.cs        = r_cs;
  assign bus.we        = r_we;
  assign bus.oe        = r_oe;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32, TIMEOUT=4) with a done-driven scoreboard.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  seen_be;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_we, seen_oe;
  logic [31:0] exp_rd;
  int          ncs, lat;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Scoreboard monitor: every done pulse consumes one expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_err"}, bus.err, e.err);
        check({e.name, "_rdata"}, bus.rdata, e.rd);
        check({e.name, "_busy_in_done"}, bus.busy, 1);
      end
    end
  end

  task automatic txn(input string name, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                     input logic rdy, input logic eerr, input logic [31:0] erd,
                     output int cs_cnt, output int latency);
    logic got;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.sign = sg; bus.addr = a;
    bus.wdata = wd; bus.mem_rdata = mrd; bus.mem_ready = 1'b0;
    exp_q.push_back('{name, eerr, erd});
    cs_cnt = 0; latency = 0; got = 1'b0;
    seen_be = '0; seen_addr = '0; seen_wdata = '0; seen_we = 1'b0; seen_oe = 1'b0;
    @(posedge clk);
    #1 bus.req = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      latency++;
      if (bus.cs) begin
        cs_cnt++;
        seen_be = bus.mem_be; seen_addr = bus.mem_addr; seen_wdata = bus.mem_wdata;
        seen_we = bus.we; seen_oe = bus.oe;
        bus.mem_ready = rdy;
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (bus.done) got = 1'b1;
    end
    bus.mem_ready = 1'b0;
    if (!got) check({name, "_done_never_seen"}, 0, 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_done"}, bus.done, 0);
    check({name, "_err"}, bus.err, 0);
    check({name, "_cs_we_oe"}, {bus.cs, bus.we, bus.oe}, 0);
    check({name, "_mem_be"}, bus.mem_be, 0);
    check({name, "_mem_addr"}, bus.mem_addr, 0);
    check({name, "_mem_wdata"}, bus.mem_wdata, 0);
    check({name, "_rdata"}, bus.rdata, 0);
  endtask

  initial begin
    bus.req = 0; bus.wr = 0; bus.size = 0; bus.sign = 0; bus.addr = 0;
    bus.wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
    exp_rd = 32'h0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Aligned word read, ready on first WAIT cycle.
    exp_rd = 32'hDEADBEEF;
    txn("word_rd", 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 1, 0, exp_rd, ncs, lat);
    check("word_rd_cs_cycles", ncs, 2);
    check("word_rd_latency", lat, 3);
    check("word_rd_be", seen_be, 4'hF);
    check("word_rd_addr", seen_addr, 32'h100);
    check("word_rd_we_oe", {seen_we, seen_oe}, 2'b01);
    @(negedge clk);
    check("word_rd_busy_after", bus.busy, 0);

    // Byte reads from the top lane, signed then unsigned.
    exp_rd = 32'hFFFFFF80;
    txn("byte_rd_s", 0, 2'b00, 1, 32'h103, 0, 32'h80112233, 1, 0, exp_rd, ncs, lat);
    check("byte_rd_s_addr", seen_addr, 32'h100);
    check("byte_rd_s_be", seen_be, 4'h8);
    exp_rd = 32'h00000080;
    txn("byte_rd_u", 0, 2'b00, 0, 32'h103, 0, 32'h80112233, 1, 0, exp_rd, ncs, lat);

    // Halfword write to upper half: rdata keeps the last read value.
    txn("half_wr", 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 1, 0, exp_rd, ncs, lat);
    check("half_wr_we_oe", {seen_we, seen_oe}, 2'b10);
    check("half_wr_be", seen_be, 4'hC);
    check("half_wr_wdata", seen_wdata, 32'hABCDABCD);
    check("half_wr_addr", seen_addr, 32'h200);

    // Misaligned word read.
`ifdef MEM_ACCESS_ARM_ROTATE_EN
    exp_rd = 32'h44112233;
    txn("mis_word_rd", 0, 2'b10, 0, 32'h101, 0, 32'h11223344, 1, 0, exp_rd, ncs, lat);
    check("mis_word_rd_cs_cycles", ncs, 2);
    check("mis_word_rd_be", seen_be, 4'hF);
    check("mis_word_rd_addr", seen_addr, 32'h100);
`else
    txn("mis_word_rd", 0, 2'b10, 0, 32'h101, 0, 32'h11223344, 1, 1, exp_rd, ncs, lat);
    check("mis_word_rd_cs_cycles", ncs, 0);
    check("mis_word_rd_latency", lat, 1);
`endif

    // Signed halfword read from the upper lanes.
    exp_rd = 32'hFFFF8001;
    txn("half_rd_s", 0, 2'b01, 1, 32'h102, 0, 32'h80017FFF, 1, 0, exp_rd, ncs, lat);
    check("half_rd_s_be", seen_be, 4'hC);

    // Misaligned halfword read, misaligned word write, illegal size: always errors.
    txn("mis_half_rd", 0, 2'b01, 0, 32'h101, 0, 32'hFFFFFFFF, 1, 1, exp_rd, ncs, lat);
    check("mis_half_rd_cs_cycles", ncs, 0);
    txn("mis_word_wr", 1, 2'b10, 0, 32'h102, 32'h12345678, 0, 1, 1, exp_rd, ncs, lat);
    check("mis_word_wr_cs_cycles", ncs, 0);
    txn("dword_illegal", 0, 2'b11, 0, 32'h108, 0, 32'h0, 1, 1, exp_rd, ncs, lat);
    check("dword_illegal_cs_cycles", ncs, 0);

    // Timeout: 4 WAIT cycles without ready.
    txn("timeout", 0, 2'b10, 0, 32'h300, 0, 32'hCAFEF00D, 0, 1, exp_rd, ncs, lat);
    check("timeout_cs_cycles", ncs, 5);
    check("timeout_latency", lat, 6);
    check("timeout_cs_after", {bus.cs, bus.oe, bus.mem_be}, 0);

    // Byte write to lane 1.
    txn("byte_wr", 1, 2'b00, 0, 32'h1, 32'h0000005A, 0, 1, 0, exp_rd, ncs, lat);
    check("byte_wr_be", seen_be, 4'h2);
    check("byte_wr_wdata", seen_wdata, 32'h5A5A5A5A);

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 0; bus.size = 2'b10; bus.sign = 0; bus.addr = 32'h400;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_cs", bus.cs, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;

    exp_rd = 32'h000000C3;
    txn("post_reset_rd", 0, 2'b00, 0, 32'h2, 0, 32'h00C30000, 1, 0, exp_rd, ncs, lat);
    check("post_reset_latency", lat, 3);
    check("post_reset_be", seen_be, 4'h4);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
